// File: rtl/spi_flash_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_flash_loader
//  Description : Reads a block of bytes from a SPI NOR flash using either the
//                single-bit read (0x03) or dual-output read (0x3B) command and
//                hands them out through a one-entry valid/ready buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_flash_loader #(
  parameter int CLKDIV = 1,   // FCK half-period in C25M cycles (1..15)
  parameter int LEN_W  = 16,  // width of the byte-count input
  parameter int DUMMY  = 8    // dummy FCK clocks in dual mode
) (
  input  logic             C25M,
  input  logic             nRES,
  input  logic             Start,
  input  logic             Dual,
  input  logic [23:0]      BaseAddr,
  input  logic [LEN_W-1:0] Len,
  input  logic             Abort,
  output logic [7:0]       Dout,
  output logic             DoutValid,
  input  logic             DoutReady,
  output logic             Busy,
  output logic             Done,
  output logic             nFCS,
  output logic             FCK,
  output logic             MOSIout,
  output logic             MOSIOE,
  input  logic             MOSI,
  input  logic             MISO
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_STALL = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [3:0] c_DIV_LAST   = 4'(CLKDIV - 1);
  localparam logic [7:0] c_DUMMY_LAST = 8'(DUMMY - 1);

  state_t           r_state, w_next;
  logic [3:0]       r_div;      // cycle counter within the current FCK phase
  logic             r_phase;    // 0 = low phase, 1 = high phase
  logic [7:0]       r_bitcnt;   // bit index within CMD/ADDR/DUMMY/byte
  logic [30:0]      r_shift;    // remaining command + address bits
  logic             r_mosi;
  logic             r_dual;
  logic [7:0]       r_rx;
  logic [7:0]       r_dout;
  logic             r_dval;
  logic             r_done;
  logic [LEN_W-1:0] r_remain;

  logic       w_shifting, w_last_cyc, w_bit_end, w_last_bit;
  logic       w_stall, w_accept, w_buf_free, w_abort;
  logic [7:0] w_rx_next, w_cmd;

  assign w_shifting = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_DUMMY) || (r_state == S_DATA);
  assign w_last_cyc = (r_div == c_DIV_LAST);
  assign w_bit_end  = w_shifting && r_phase && w_last_cyc;
  assign w_last_bit = (r_bitcnt == (r_dual ? 8'd3 : 8'd7));
  // Freeze FCK low just before the rising edge of a byte's final bit while the
  // previous byte still occupies the output buffer.
  assign w_stall    = (r_state == S_DATA) && !r_phase && w_last_cyc &&
                      w_last_bit && r_dval && !DoutReady;
  assign w_accept   = r_dval && DoutReady;
  assign w_buf_free = !r_dval || DoutReady;
  assign w_abort    = Abort && (r_state != S_IDLE);
  assign w_rx_next  = r_dual ? {r_rx[5:0], MISO, MOSI} : {r_rx[6:0], MISO};
  assign w_cmd      = Dual ? 8'h3B : 8'h03;

  assign Dout      = r_dout;
  assign DoutValid = r_dval;
  assign Busy      = (r_state != S_IDLE);
  assign Done      = r_done;
  assign nFCS      = !(w_shifting || (r_state == S_STALL));
  assign FCK       = r_phase;
  assign MOSIout   = r_mosi;
  assign MOSIOE    = (r_state == S_CMD) || (r_state == S_ADDR);

  // State register
  always_ff @(posedge C25M or negedge nRES) begin
    if (!nRES) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; Abort wins over everything outside IDLE
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (Start && (Len != '0)) w_next = S_CMD;
        S_CMD:   if (w_bit_end && (r_bitcnt == 8'd7)) w_next = S_ADDR;
        S_ADDR:  if (w_bit_end && (r_bitcnt == 8'd23))
                   w_next = (r_dual && (DUMMY != 0)) ? S_DUMMY : S_DATA;
        S_DUMMY: if (w_bit_end && (r_bitcnt == c_DUMMY_LAST)) w_next = S_DATA;
        S_DATA:  begin
          if (w_stall) w_next = S_STALL;
          else if (w_bit_end && w_last_bit && (r_remain == LEN_W'(1))) w_next = S_FIN;
        end
        S_STALL: if (w_buf_free) w_next = S_DATA;
        S_FIN:   if (w_buf_free) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Bit timing, shifters, byte counter and output buffer
  always_ff @(posedge C25M or negedge nRES) begin
    if (!nRES) begin
      r_div    <= '0;
      r_phase  <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_mosi   <= 1'b0;
      r_dual   <= 1'b0;
      r_rx     <= '0;
      r_dout   <= '0;
      r_dval   <= 1'b0;
      r_done   <= 1'b0;
      r_remain <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) r_dval <= 1'b0;
      if (w_abort) begin
        r_div    <= '0;
        r_phase  <= 1'b0;
        r_bitcnt <= '0;
        r_mosi   <= 1'b0;
        r_dval   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_div    <= '0;
            r_phase  <= 1'b0;
            r_bitcnt <= '0;
            if (Start) begin
              if (Len == '0) begin
                r_done <= 1'b1;
              end else begin
                r_shift  <= {w_cmd[6:0], BaseAddr};
                r_mosi   <= w_cmd[7];
                r_remain <= Len;
                r_dual   <= Dual;
              end
            end
          end
          S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
            if (!w_last_cyc) begin
              r_div <= r_div + 4'd1;
            end else begin
              r_div <= '0;
              if (!r_phase) begin
                r_phase <= !w_stall;
              end else begin
                r_phase <= 1'b0;
                case (r_state)
                  S_CMD: begin
                    r_shift  <= {r_shift[29:0], 1'b0};
                    r_mosi   <= r_shift[30];
                    r_bitcnt <= (r_bitcnt == 8'd7) ? 8'd0 : r_bitcnt + 8'd1;
                  end
                  S_ADDR: begin
                    r_shift <= {r_shift[29:0], 1'b0};
                    if (r_bitcnt == 8'd23) begin
                      r_mosi   <= 1'b0;
                      r_bitcnt <= '0;
                    end else begin
                      r_mosi   <= r_shift[30];
                      r_bitcnt <= r_bitcnt + 8'd1;
                    end
                  end
                  S_DUMMY: r_bitcnt <= (r_bitcnt == c_DUMMY_LAST) ? 8'd0 : r_bitcnt + 8'd1;
                  default: begin
                    if (w_last_bit) begin
                      r_dout   <= w_rx_next;
                      r_dval   <= 1'b1;
                      r_remain <= r_remain - LEN_W'(1);
                      r_bitcnt <= '0;
                    end else begin
                      r_rx     <= w_rx_next;
                      r_bitcnt <= r_bitcnt + 8'd1;
                    end
                  end
                endcase
              end
            end
          end
          S_STALL: begin
            // Resume directly into the high phase of the held bit
            r_div <= '0;
            if (w_buf_free) r_phase <= 1'b1;
          end
          S_FIN: begin
            if (w_buf_free) r_done <= 1'b1;
          end
          default: begin
            r_phase <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_loader.md
SPI_FLASH_LOADER -- requirements
Module: spi_flash_loader

Interface
REQ-001 SHALL have parameter CLKDIV, default 1: FCK half-period in C25M cycles, legal range 1..15.
REQ-002 SHALL have parameter LEN_W, default 16: width of byte-count input.
REQ-003 SHALL have parameter DUMMY, default 8: dummy FCK clocks in dual mode.
REQ-004 C25M  in  1  sole clock; all state changes on its rising edge.
REQ-005 nRES  in  1  asynchronous, active-low reset.
REQ-006 Start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 Dual  in  1  sampled with Start: 0 = read 0x03, 1 = dual-output read 0x3B.
REQ-008 BaseAddr  in  24  flash start address, sampled with Start.
REQ-009 Len  in  LEN_W  byte count, sampled with Start.
REQ-010 Abort  in  1  terminates any active transfer.
REQ-011 Dout  out  8  received byte.
REQ-012 DoutValid  out  1  Dout holds an unaccepted byte.
REQ-013 DoutReady  in  1  consumer accepts Dout when both Valid and Ready are high on a clock edge.
REQ-014 Busy  out  1  high outside IDLE.
REQ-015 Done  out  1  one-cycle pulse on normal completion.
REQ-016 nFCS  out  1  flash chip select, active low.
REQ-017 FCK  out  1  flash clock, SPI mode 0, idles low.
REQ-018 MOSIout/MOSIOE  out  1/1  IO0 drive value and enable.
REQ-019 MOSI  in  1  IO0 pin readback (dual data).
REQ-020 MISO  in  1  IO1 (single and dual data).

Function
REQ-021 FSM states SHALL be IDLE, CMD, ADDR, DUMMY, DATA, STALL, FIN.
REQ-022 Start in IDLE with Len!=0 SHALL enter CMD; nFCS low from the following cycle.
REQ-023 Start with Len==0 SHALL produce Done the next cycle, with nFCS held high and no FCK activity.
REQ-024 Bit timing: each FCK bit SHALL be CLKDIV cycles low, then CLKDIV cycles high.
REQ-025 MOSIout SHALL update on the first cycle of each low phase.
REQ-026 Input bits SHALL be sampled on the last cycle of each high phase.
REQ-027 CMD SHALL shift 8 bits MSB first; ADDR SHALL shift BaseAddr[23:0] MSB first, single-bit on IO0 in both modes.
REQ-028 DUMMY SHALL run only when Dual=1, for DUMMY clocks, with MOSIOE low.
REQ-029 MOSIOE SHALL be high in CMD and ADDR and low elsewhere.
REQ-030 DATA, single mode: 8 clocks per byte, MISO MSB first.
REQ-031 DATA, dual mode: 4 clocks per byte, {MISO,MOSI} per clock, first pair = bits 7:6.
REQ-032 Output is a one-entry buffer: a completed byte SHALL load Dout and set DoutValid the cycle after its final sample.
REQ-033 If DoutValid is still high (not accepted) when the next byte's final sample is due, FSM SHALL enter STALL with FCK held low.
REQ-034 STALL SHALL resume the cycle after acceptance; no bit is lost or duplicated.
REQ-035 Remaining count SHALL decrement per completed byte; LEN_W-bit, no wrap (Len max = 2^LEN_W-1).
REQ-036 After the last byte: FIN, nFCS high, FCK low; Done SHALL pulse once the last byte is accepted.
REQ-037 Abort SHALL override Start and all other inputs in any non-IDLE state.
REQ-038 On Abort the next cycle SHALL show nFCS=1, FCK=0, MOSIOE=0, DoutValid=0, Busy=0, with no Done.
REQ-039 Start while Busy SHALL be ignored.
REQ-040 Dout SHALL remain stable while DoutValid is high.

Reset
REQ-041 While nRES is low, outputs SHALL be: nFCS=1, FCK=0, MOSIout=0, MOSIOE=0, Dout=0, DoutValid=0, Busy=0, Done=0, FSM in IDLE.
REQ-042 Reset SHALL take effect mid-transfer without a Done pulse; the first Start after release SHALL be honoured.

Verification
REQ-043 Single read, CLKDIV=1, Dual=0, BaseAddr=0x012345, Len=1, Ready=1 -> MOSI carries 0x03,0x01,0x23,0x45 -> 80 cycles of FCK activity -> Dout=model byte -> Done; nFCS low for 80+ cycles.
REQ-044 Dual, CLKDIV=2, Len=4, model bytes A5,5A,FF,00 -> command 0x3B, 8 dummy clocks with MOSIOE=0, 4 clocks/byte -> Dout sequence A5,5A,FF,00.
REQ-045 Backpressure: Ready low for 20 cycles after byte 0, Len=3 -> FCK low through STALL -> bytes intact, no extra FCK edges.
REQ-046 Abort mid-ADDR, then reset mid-DATA -> nFCS=1 next cycle, no Done, Busy=0 -> a subsequent Start completes normally.
REQ-047 Len=0 Start -> Done the next cycle, nFCS never low; Start during Busy -> ignored, transfer count unchanged.
